// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring arbiter.
// Provides the FSM state enum and the ring wrap-increment used for handoff.
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next index around the ring: i -> i+1, n-1 -> 0.
    function automatic int unsigned wrap_inc(
        input int unsigned i,
        input int unsigned n
    );
        return (i == n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/ring_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Ports: en, req[N], done toward the arbiter; gnt[N], gnt_id, gnt_valid, timeout back.
interface ring_arbiter_if #(
    parameter int N = 7
) ();
    localparam int W = $clog2(N);

    logic         en;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_id;
    logic         gnt_valid;
    logic         timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/ring_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit scanning from ptr upward.
// Ports: req[N], ptr[W] in; found, idx[W] out.
module rr_pick #(
    parameter int N = 7,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    localparam logic [W:0] NV = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotating the doubled vector puts ptr at bit 0, so the wrap is free.
    assign dbl = {req, req} >> ptr;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                found = 1'b1;
                off   = W'(k);
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= NV) ? W'(sum - NV) : W'(sum);
endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a hold limit; one registered one-hot grant at a time.
// Ports: clock, reset (sync, active-high), bus (ring_arbiter_if.slave).
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N       = 7,
    parameter int MAXHOLD = 8,
    localparam int W      = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    ring_arbiter_if.slave bus
);
    localparam int CW = (MAXHOLD < 2) ? 1 : $clog2(MAXHOLD);

    state_t         state;
    logic [W-1:0]   ptr;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   ptr_next;
    logic [W-1:0]   pick_ptr;
    logic           found;
    logic [W-1:0]   idx;
    logic           limit;
    logic           rel;

    assign limit    = (MAXHOLD > 0) && (cnt == CW'(MAXHOLD - 1));
    assign rel      = (state == GRANT) && (bus.done || limit);
    assign ptr_next = W'(wrap_inc(32'(bus.gnt_id), unsigned'(N)));

    // A releasing grant searches from the successor, an idle one from ptr.
    assign pick_ptr = (state == GRANT) ? ptr_next : ptr;

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.gnt_id    <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else if (!bus.en) begin
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state         <= GRANT;
                        bus.gnt       <= {{(N-1){1'b0}}, 1'b1} << idx;
                        bus.gnt_id    <= idx;
                        bus.gnt_valid <= 1'b1;
                        cnt           <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr         <= ptr_next;
                        cnt         <= '0;
                        // done beats the limit when both land together
                        bus.timeout <= !bus.done;
                        if (found) begin
                            bus.gnt    <= {{(N-1){1'b0}}, 1'b1} << idx;
                            bus.gnt_id <= idx;
                        end else begin
                            state         <= IDLE;
                            bus.gnt       <= '0;
                            bus.gnt_valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_arbiter.sv
// Self-checking bench for ring_arbiter: directed steps then random traffic.
// Compares every cycle against a queue-free ring/tenure reference model.
module tb_ring_arbiter;
    localparam int N       = 7;
    localparam int MAXHOLD = 8;
    localparam int W       = $clog2(N);

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ring_arbiter_if #(.N(N)) bus ();

    ring_arbiter #(.N(N), .MAXHOLD(MAXHOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, how long, and where the ring points.
    int m_ptr   = 0;
    int m_owner = -1;
    int m_id    = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  i;
        bit  rel;
        if (reset) begin
            m_ptr = 0; m_owner = -1; m_id = 0; m_held = 0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (!bus.en) return;
        if (m_owner < 0) begin
            i = pick(m_ptr, bus.req);
            if (i >= 0) begin
                m_owner = i; m_id = i; m_held = 0;
            end
        end else begin
            rel = 1'b0;
            if (bus.done) begin
                rel = 1'b1;
            end else if (MAXHOLD > 0 && m_held + 1 == MAXHOLD) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end
            if (rel) begin
                m_ptr  = (m_owner + 1) % N;
                m_held = 0;
                i = pick(m_ptr, bus.req);
                if (i >= 0) begin
                    m_owner = i; m_id = i;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        n_checks++;
        assert (bus.gnt === eg) else begin
            n_fail++;
            $error("FAIL %s gnt got %b want %b", tag, bus.gnt, eg);
        end
        n_checks++;
        assert (bus.gnt_valid === (m_owner >= 0)) else begin
            n_fail++;
            $error("FAIL %s gnt_valid got %b want %b", tag, bus.gnt_valid, m_owner >= 0);
        end
        n_checks++;
        assert (bus.gnt_id === W'(m_id)) else begin
            n_fail++;
            $error("FAIL %s gnt_id got %0d want %0d", tag, bus.gnt_id, m_id);
        end
        n_checks++;
        assert (bus.timeout === m_to) else begin
            n_fail++;
            $error("FAIL %s timeout got %b want %b", tag, bus.timeout, m_to);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check(tag);
    endtask

    // Directed constant checks independent of the model.
    task automatic expect_out(input string tag, input bit v, input int id, input bit to);
        n_checks++;
        assert (bus.gnt_valid === v && (!v || bus.gnt_id === W'(id)) && bus.timeout === to)
        else begin
            n_fail++;
            $error("FAIL %s got v=%b id=%0d to=%b want v=%b id=%0d to=%b",
                   tag, bus.gnt_valid, bus.gnt_id, bus.timeout, v, id, to);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.en   = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        cycle("reset");
        expect_out("reset_state", 1'b0, 0, 1'b0);
        reset = 1'b0;
        cycle("idle");

        // single requester, then release to idle (ptr -> 3)
        bus.req = 7'b0000100;
        cycle("grant2");
        expect_out("grant2", 1'b1, 2, 1'b0);
        bus.req = '0; bus.done = 1'b1;
        cycle("rel2");
        bus.done = 1'b0;
        expect_out("rel2_idle", 1'b0, 0, 1'b0);

        // ring order from ptr 3: 6, 0, 2 back-to-back
        bus.req = 7'b1000101;
        cycle("grant6");
        expect_out("grant6", 1'b1, 6, 1'b0);
        bus.done = 1'b1;
        cycle("grant0");
        expect_out("grant0", 1'b1, 0, 1'b0);
        cycle("grant2b");
        expect_out("grant2b", 1'b1, 2, 1'b0);
        bus.req = '0;
        cycle("to_idle");
        expect_out("to_idle", 1'b0, 0, 1'b0);
        bus.done = 1'b0;

        // hold limit on sole requester 4
        bus.req = 7'b0010000;
        cycle("grant4");
        for (int i = 0; i < MAXHOLD - 1; i++) cycle("hold4");
        expect_out("hold4_last", 1'b1, 4, 1'b0);
        cycle("timeout4");
        expect_out("timeout4", 1'b1, 4, 1'b1);
        cycle("after_to4");
        expect_out("after_to4", 1'b1, 4, 1'b0);
        bus.req = '0; bus.done = 1'b1;
        cycle("rel4");
        bus.done = 1'b0;

        // freeze with en=0, done ignored
        bus.req = 7'b0000010;
        cycle("grant1");
        cycle("hold1");
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.done = (i == 2);
            cycle("frozen1");
        end
        expect_out("frozen1", 1'b1, 1, 1'b0);
        bus.en = 1'b1; bus.done = 1'b1; bus.req = '0;
        cycle("rel1");
        expect_out("rel1", 1'b0, 0, 1'b0);
        bus.done = 1'b0;

        // done coincides with the hold limit
        bus.req = 7'b0001000;
        cycle("grant3");
        for (int i = 0; i < MAXHOLD - 1; i++) cycle("hold3");
        bus.done = 1'b1; bus.req = '0;
        cycle("done_at_limit");
        expect_out("done_at_limit", 1'b0, 0, 1'b0);
        bus.done = 1'b0;

        // reset mid-grant with en=0
        bus.req = 7'b0100000;
        cycle("grant5");
        expect_out("grant5", 1'b1, 5, 1'b0);
        reset = 1'b1; bus.en = 1'b0;
        cycle("reset_mid");
        expect_out("reset_mid", 1'b0, 0, 1'b0);
        reset = 1'b0; bus.en = 1'b1; bus.req = 7'b1111111;
        cycle("all_req");
        expect_out("all_req", 1'b1, 0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            bus.en   = ($urandom_range(0, 99) < 85);
            bus.req  = N'($urandom);
            if ($urandom_range(0, 3) == 0) bus.req = '0;
            bus.done = ($urandom_range(0, 99) < 20);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_arbiter.md
Name: ring_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters, using the same ring ordering as the team's 7-state ring FSM: requester i hands off to i+1, and N-1 wraps to 0.
- Sits between request sources and a shared datapath unit, and issues exactly one registered grant at a time.
- Owner releases the grant with `done`; a hold counter enforces a maximum tenure; a global `en` freezes the arbiter.

Parameters:
- N, 7, number of requesters (N >= 2).
- MAXHOLD, 8, maximum grant tenure in enabled cycles; 0 disables the timeout.
- W, $clog2(N), localparam, width of requester index.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  global enable; when 0 all state holds.
- req  in  N  per-requester request level.
- done  in  1  current grant owner releases, single-cycle pulse.
- gnt  out  N  one-hot grant, registered.
- gnt_id  out  W  index of granted requester, valid when gnt_valid=1.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Register updates occur on `posedge clock`. `reset` has priority over `en`.
- Reset values: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, cnt=0.
- Enable:
  - en=0: state, ptr, cnt and all outputs hold.
  - timeout is forced to 0 on any cycle where en=0.
  - done and req are ignored while en=0.
- States: IDLE, GRANT.
- Pick function, given ptr and req:
  - Select the first i with req[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - "none" if req=0.
- IDLE, en=1:
  - If pick found: next cycle state=GRANT, gnt=onehot(i), gnt_id=i, gnt_valid=1, cnt=0.
  - Otherwise stay in IDLE.
  - Latency: req to gnt is 1 cycle.
- GRANT, en=1:
  - Release occurs if done=1, or if MAXHOLD>0 and cnt==MAXHOLD-1.
  - No release: cnt++, grant held.
  - req[gnt_id] dropping does NOT release; only done or timeout does.
  - On release: ptr_next = (gnt_id==N-1) ? 0 : gnt_id+1.
  - Pick is evaluated against ptr_next and the current req.
  - If found: stay in GRANT with the new grant next cycle, cnt=0. Back-to-back, no dead cycle.
  - If none: go to IDLE with gnt=0 and gnt_valid=0 next cycle.
  - The releasing requester can be re-granted immediately only if it is the sole requester.
- Timeout:
  - timeout=1 for one cycle, aligned with the cycle the grant changes or drops, only when release was caused by the hold limit.
  - done and the limit in the same cycle: done wins, timeout=0.
- ptr changes only on release. An IDLE grant does not move ptr.
- gnt is always one-hot or zero. gnt_valid == |gnt. gnt_id holds its last value while in IDLE.
- Reset mid-grant: the grant is dropped next cycle and ptr returns to 0.
- done in IDLE: ignored.

Decomposition:
- Package ring_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Wrap-increment function, index modulo N.
- Sub-module rr_pick: combinational. Inputs req[N], ptr[W]; outputs found, idx[W]. Implemented as a double-width priority scan. Instantiated once, fed with a mux of ptr and ptr_next.
- Top level holds the FSM, ptr, cnt and output registers.

Test Plan:
- Reset, then req=7'b0000100 -> 1 cycle later gnt=7'b0000100, gnt_id=2, gnt_valid=1; after done pulse -> gnt=0 next cycle, ptr=3.
- With ptr=3, req=7'b1000101 -> gnt_id=6; done -> gnt_id=0 with no idle gap; done -> gnt_id=2; done -> IDLE.
- req[4] held, no done, MAXHOLD=8 -> gnt held exactly 8 cycles, timeout pulses once, then gnt_id=4 re-granted (sole requester), cnt restarts.
- Granted id=1, en=0 for 5 cycles with done pulsed inside that window -> no change, cnt frozen, done ignored; with en=1, done -> release.
- done and hold limit coincide on cycle 8 -> release with timeout=0.
- Mid-grant (id=5) reset=1 with en=0 -> next cycle gnt=0, gnt_valid=0, timeout=0; then req=7'b1111111 -> gnt_id=0.
